dift_tag_check: RTL and testbench

Tag Check Unit of the DIFT extension: the consuming end of the tag path that the Tag Propagation Unit feeds. For each instruction leaving EX it checks operand and instruction tags against the TCCR (tag check configuration register) policy. On a violation it halts the pipeline, raises a held exception request to the controller, and captures PC and cause. It sits in the EX stage next to the propagation unit and talks to the controller through a req/ack handshake.

---
 rtl/dift_tag_check_pkg.sv | 45 ++++
 rtl/dift_sat_counter.sv | 42 ++++
 rtl/dift_tag_check.sv | 126 ++++++++++++
 tb/tb_dift_tag_check.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dift_tag_check_pkg.sv
// Shared types for the DIFT tag check unit: tag type, check policy,
// instruction classes and violation cause codes.
package dift_tag_check_pkg;

  localparam int DIFT_TAG_SIZE = 2;
  typedef logic [DIFT_TAG_SIZE-1:0] dift_tag_t;

  typedef struct packed {
    logic exec_en;
    logic jalr_en;
    logic bran_en;
    logic load_en;
    logic stor_addr_en;
    logic stor_data_en;
    logic trap_en;
  } dift_tccr_t;

  typedef enum logic [2:0] {
    OPC_NONE  = 3'd0,
    OPC_JALR  = 3'd1,
    OPC_BRAN  = 3'd2,
    OPC_LOAD  = 3'd3,
    OPC_STOR  = 3'd4,
    OPC_OTHER = 3'd5
  } dift_check_opclass_t;

  typedef logic [2:0] dift_check_cause_t;

  localparam dift_check_cause_t DIFT_CHECK_CAUSE_EXEC      = 3'd0;
  localparam dift_check_cause_t DIFT_CHECK_CAUSE_JALR      = 3'd1;
  localparam dift_check_cause_t DIFT_CHECK_CAUSE_BRAN      = 3'd2;
  localparam dift_check_cause_t DIFT_CHECK_CAUSE_LOAD      = 3'd3;
  localparam dift_check_cause_t DIFT_CHECK_CAUSE_STOR_ADDR = 3'd4;
  localparam dift_check_cause_t DIFT_CHECK_CAUSE_STOR_DATA = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } dift_check_state_t;

  function automatic logic tag_tainted(input dift_tag_t tag);
    return |tag;
  endfunction

endpackage

// File: rtl/dift_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment in the
// same cycle loads one so the coincident event is not lost.
module dift_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i && inc_i) begin
      cnt_d = CNT_ONE;
    end else if (clr_i) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dift_tag_check.sv
// DIFT tag check unit: checks EX-stage tags against the TCCR policy, halts
// and raises a held exception request on a trapping violation.
module dift_tag_check
  import dift_tag_check_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  dift_tccr_t           tccr_i,
  input  logic                 valid_i,
  input  dift_check_opclass_t  opclass_i,
  input  logic                 rega_used_i,
  input  logic                 regb_used_i,
  input  dift_tag_t            instr_tag_i,
  input  dift_tag_t            operand_a_tag_i,
  input  dift_tag_t            operand_b_tag_i,
  input  logic [31:0]          pc_i,
  output logic                 halt_o,
  output logic                 exc_req_o,
  input  logic                 exc_ack_i,
  output dift_check_cause_t    exc_cause_o,
  output logic [31:0]          exc_pc_o,
  input  logic                 cnt_clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  dift_check_state_t state_q, state_d;
  dift_check_cause_t cause_q, cause_d;
  logic [31:0]       pc_q, pc_d;

  logic i_taint_s, a_taint_s, b_taint_s;
  logic c_exec_s, c_jalr_s, c_bran_s, c_load_s, c_sa_s, c_sd_s;
  logic viol_s, capture_s;
  dift_check_cause_t cause_s;

  assign i_taint_s = tag_tainted(instr_tag_i);
  assign a_taint_s = tag_tainted(operand_a_tag_i);
  assign b_taint_s = tag_tainted(operand_b_tag_i);

  assign c_exec_s = valid_i & tccr_i.exec_en & i_taint_s;
  assign c_jalr_s = valid_i & tccr_i.jalr_en & (opclass_i == OPC_JALR) & a_taint_s;
  assign c_bran_s = valid_i & tccr_i.bran_en & (opclass_i == OPC_BRAN) &
                    ((rega_used_i & a_taint_s) | (regb_used_i & b_taint_s));
  assign c_load_s = valid_i & tccr_i.load_en & (opclass_i == OPC_LOAD) & a_taint_s;
  assign c_sa_s   = valid_i & tccr_i.stor_addr_en & (opclass_i == OPC_STOR) & a_taint_s;
  assign c_sd_s   = valid_i & tccr_i.stor_data_en & (opclass_i == OPC_STOR) &
                    regb_used_i & b_taint_s;

  // No evaluation while a request is pending: the pipeline is frozen then.
  assign viol_s    = (state_q == ST_IDLE) &
                     (c_exec_s | c_jalr_s | c_bran_s | c_load_s | c_sa_s | c_sd_s);
  assign capture_s = viol_s & tccr_i.trap_en;

  always_comb begin
    cause_s = DIFT_CHECK_CAUSE_EXEC;
    if (c_exec_s) begin
      cause_s = DIFT_CHECK_CAUSE_EXEC;
    end else if (c_jalr_s) begin
      cause_s = DIFT_CHECK_CAUSE_JALR;
    end else if (c_bran_s) begin
      cause_s = DIFT_CHECK_CAUSE_BRAN;
    end else if (c_load_s) begin
      cause_s = DIFT_CHECK_CAUSE_LOAD;
    end else if (c_sa_s) begin
      cause_s = DIFT_CHECK_CAUSE_STOR_ADDR;
    end else begin
      cause_s = DIFT_CHECK_CAUSE_STOR_DATA;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_s) begin
          state_d = ST_REQ;
          cause_d = cause_s;
          pc_d    = pc_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (exc_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= DIFT_CHECK_CAUSE_EXEC;
      pc_q    <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  assign halt_o      = capture_s | (state_q == ST_REQ);
  assign exc_req_o   = (state_q == ST_REQ);
  assign exc_cause_o = cause_q;
  assign exc_pc_o    = pc_q;

  dift_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr_i),
    .inc_i (viol_s),
    .cnt_o (cnt_o)
  );

endmodule

// File: tb/tb_dift_tag_check.sv
// Scoreboard bench for dift_tag_check: expected exceptions are queued at the
// violation cycle and matched by a monitor when exc_req_o rises.
module tb_dift_tag_check;
  import dift_tag_check_pkg::*;

  typedef struct {
    logic [2:0]  cause;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  dift_tccr_t tccr;
  logic valid, rega_used, regb_used, ack, clr;
  dift_check_opclass_t opclass;
  dift_tag_t itag, atag, btag;
  logic [31:0] pc;
  logic halt, req, halt4, req4;
  dift_check_cause_t cause, cause4;
  logic [31:0] epc, epc4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic req_prev = 1'b0;

  always #5 clk = ~clk;

  dift_tag_check #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tccr_i(tccr), .valid_i(valid), .opclass_i(opclass),
    .rega_used_i(rega_used), .regb_used_i(regb_used), .instr_tag_i(itag),
    .operand_a_tag_i(atag), .operand_b_tag_i(btag), .pc_i(pc), .halt_o(halt),
    .exc_req_o(req), .exc_ack_i(ack), .exc_cause_o(cause), .exc_pc_o(epc),
    .cnt_clr_i(clr), .cnt_o(cnt)
  );

  dift_tag_check #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .tccr_i(tccr), .valid_i(valid), .opclass_i(opclass),
    .rega_used_i(rega_used), .regb_used_i(regb_used), .instr_tag_i(itag),
    .operand_a_tag_i(atag), .operand_b_tag_i(btag), .pc_i(pc), .halt_o(halt4),
    .exc_req_o(req4), .exc_ack_i(ack), .exc_cause_o(cause4), .exc_pc_o(epc4),
    .cnt_clr_i(clr), .cnt_o(cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: each rising exc_req_o must match the oldest queued exception.
  always @(negedge clk) begin
    if (req && !req_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: cause %0d pc 0x%0h with no expectation", cause, epc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_cause", {29'd0, cause}, {29'd0, e.cause});
        chk("sb_pc", epc, e.pc);
      end
    end
    req_prev <= req;
  end

  task automatic idle_in();
    valid = 1'b0; opclass = OPC_NONE; rega_used = 1'b0; regb_used = 1'b0;
    itag = 2'b00; atag = 2'b00; btag = 2'b00; pc = 32'h0000_0000;
    ack = 1'b0; clr = 1'b0;
  endtask

  task automatic set_in(input logic [6:0] t, input dift_check_opclass_t o,
                        input logic ra, input logic rb, input dift_tag_t it,
                        input dift_tag_t at, input dift_tag_t bt, input logic [31:0] p);
    tccr = dift_tccr_t'(t); valid = 1'b1; opclass = o; rega_used = ra; regb_used = rb;
    itag = it; atag = at; btag = bt; pc = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Trapping violation already driven: check halt, queue expectation, hold, ack.
  task automatic trap(input logic [2:0] c, input logic [31:0] p, input int hold);
    @(negedge clk);
    chk("halt_viol", {31'd0, halt}, 32'd1);
    exp_q.push_back('{cause: c, pc: p});
    exp_cnt++;
    step();
    idle_in();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("req_held", {31'd0, req}, 32'd1);
      chk("halt_held", {31'd0, halt}, 32'd1);
      if (i == hold - 1) ack = 1'b1;
      step();
    end
    ack = 1'b0;
    @(negedge clk);
    chk("req_after_ack", {31'd0, req}, 32'd0);
    chk("cause_hold", {29'd0, cause}, {29'd0, c});
    chk("pc_hold", epc, p);
    chk("cnt_trap", {16'd0, cnt}, exp_cnt);
  endtask

  // Bit order: exec jalr bran load stor_addr stor_data trap
  initial begin
    tccr = dift_tccr_t'(7'b0000000);
    idle_in();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_cause", {29'd0, cause}, 32'd0);
    chk("rst_pc", epc, 32'd0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);

    step(); set_in(7'b0001001, OPC_LOAD, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 32'h0000_0100);
    trap(3'd3, 32'h0000_0100, 5);

    step(); set_in(7'b0000111, OPC_STOR, 1'b1, 1'b1, 2'b00, 2'b10, 2'b01, 32'h0000_0104);
    trap(3'd4, 32'h0000_0104, 1);
    step(); set_in(7'b0000011, OPC_STOR, 1'b1, 1'b1, 2'b00, 2'b10, 2'b01, 32'h0000_0108);
    trap(3'd5, 32'h0000_0108, 1);

    step(); set_in(7'b0010001, OPC_BRAN, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 32'h0000_010C);
    @(negedge clk);
    chk("bran_unused_halt", {31'd0, halt}, 32'd0);
    step(); idle_in();
    @(negedge clk);
    chk("bran_unused_req", {31'd0, req}, 32'd0);
    chk("bran_unused_cnt", {16'd0, cnt}, exp_cnt);
    step(); set_in(7'b0010001, OPC_BRAN, 1'b1, 1'b1, 2'b00, 2'b00, 2'b11, 32'h0000_0110);
    trap(3'd2, 32'h0000_0110, 2);

    step(); set_in(7'b1100001, OPC_JALR, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 32'h0000_0114);
    trap(3'd0, 32'h0000_0114, 1);

    for (int i = 0; i < 3; i++) begin
      step(); set_in(7'b0100000, OPC_JALR, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 32'h0000_0200 + i);
      @(negedge clk);
      chk("count_only_halt", {31'd0, halt}, 32'd0);
    end
    exp_cnt += 3;
    step(); idle_in();
    @(negedge clk);
    chk("count_only_req", {31'd0, req}, 32'd0);
    chk("count_only_cnt", {16'd0, cnt}, exp_cnt);

    step(); set_in(7'b0100000, OPC_JALR, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 32'h0000_0300);
    clr = 1'b1;
    step(); idle_in();
    @(negedge clk);
    exp_cnt = 1;
    chk("clr_inc_cnt", {16'd0, cnt}, 32'd1);
    chk("clr_inc_cnt4", {28'd0, cnt4}, 32'd1);

    step(); clr = 1'b1;
    step(); clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_in(7'b0100000, OPC_JALR, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 32'h0000_0400);
      step();
    end
    idle_in();
    @(negedge clk);
    chk("sat_cnt4", {28'd0, cnt4}, 32'd15);
    chk("wide_cnt", {16'd0, cnt}, 32'd20);
    step(); clr = 1'b1;
    step(); clr = 1'b0;
    @(negedge clk);
    chk("sat_clr_cnt4", {28'd0, cnt4}, 32'd0);
    chk("sat_clr_cnt", {16'd0, cnt}, 32'd0);

    step(); set_in(7'b1000001, OPC_OTHER, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 32'h0000_0500);
    @(negedge clk);
    chk("rst_req_halt", {31'd0, halt}, 32'd1);
    exp_q.push_back('{cause: 3'd0, pc: 32'h0000_0500});
    step(); idle_in();
    @(negedge clk);
    chk("rst_req_pending", {31'd0, req}, 32'd1);
    rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("midreq_rst_req", {31'd0, req}, 32'd0);
    chk("midreq_rst_idle", {31'd0, halt}, 32'd0);
    chk("midreq_rst_cnt", {16'd0, cnt}, 32'd0);
    exp_cnt = 0;

    step(); set_in(7'b0001001, OPC_LOAD, 1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 32'h0000_0600);
    trap(3'd3, 32'h0000_0600, 2);

    step();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
